regfile_wb_arbiter: RTL



---
 rtl/regfile_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 61 ++++++
 rtl/regfile_wb_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared widths, zero-register address and data/address types for the register file
// writeback path.
package regfile_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 5;

  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer;
// the pointer moves past the granted index when the grant is consumed.
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         en,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;

  logic [PtrW-1:0] ptr_q;
  logic [PtrW-1:0] ptr_d;
  logic [PtrW-1:0] gnt_idx;
  logic [PtrW-1:0] sel;
  logic            found;
  int unsigned     idx;

  always_comb begin
    grant   = '0;
    gnt_idx = ptr_q;
    found   = 1'b0;
    idx     = 0;
    sel     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      // Scan ptr, ptr+1, ... wrapping at N (N need not be a power of two).
      idx = 32'(ptr_q) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      sel = PtrW'(idx);
      if (!found && en && req[sel]) begin
        grant[sel] = 1'b1;
        gnt_idx    = sel;
        found      = 1'b1;
      end
    end

    ptr_d = ptr_q;
    if (advance && found) begin
      if (32'(gnt_idx) == N - 1) begin
        ptr_d = '0;
      end else begin
        ptr_d = gnt_idx + PtrW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among NUM_REQ valid/ready requesters with a
// registered output stage. Optional read-bypass ports under REGFILE_WB_FORWARD_EN.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned DATA_W  = regfile_pkg::DATA_W,
  parameter int unsigned ADDR_W  = regfile_pkg::ADDR_W,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                        Clk,
  input  logic                        Rst_n,
  input  logic                        Hold,
  input  logic [NUM_REQ-1:0]          ReqValid,
  output logic [NUM_REQ-1:0]          ReqReady,
  input  logic [NUM_REQ*ADDR_W-1:0]   ReqRW,
  input  logic [NUM_REQ*DATA_W-1:0]   ReqBusW,
  output logic                        RegWr,
  output logic [ADDR_W-1:0]           RW,
  output logic [DATA_W-1:0]           BusW,
  output logic [CNT_W-1:0]            WrCount,
`ifdef REGFILE_WB_FORWARD_EN
  input  logic [ADDR_W-1:0]           RA,
  input  logic [ADDR_W-1:0]           RB,
  input  logic [DATA_W-1:0]           BusA_in,
  input  logic [DATA_W-1:0]           BusB_in,
  output logic [DATA_W-1:0]           BusA_fwd,
  output logic [DATA_W-1:0]           BusB_fwd,
`endif
  output logic [CNT_W-1:0]            DropCount
);

  localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(ZERO_REG);

  logic [NUM_REQ-1:0] grant;
  logic               arb_en;
  logic               transfer;
  logic [ADDR_W-1:0]  sel_rw;
  logic [DATA_W-1:0]  sel_busw;
  logic               sel_is_zero;

  logic               regwr_q,    regwr_d;
  logic [ADDR_W-1:0]  rw_q,       rw_d;
  logic [DATA_W-1:0]  busw_q,     busw_d;
  logic [CNT_W-1:0]   wr_cnt_q,   wr_cnt_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

  // Reset also blanks the grant so nothing is accepted while the stage is being cleared.
  assign arb_en   = Rst_n & ~Hold;
  assign transfer = |(ReqValid & grant);
  assign ReqReady = grant;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr_arbiter (
    .clk     (Clk),
    .rst_n   (Rst_n),
    .req     (ReqValid),
    .en      (arb_en),
    .advance (transfer),
    .grant   (grant)
  );

  always_comb begin
    sel_rw   = '0;
    sel_busw = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_rw   = ReqRW[i*ADDR_W +: ADDR_W];
        sel_busw = ReqBusW[i*DATA_W +: DATA_W];
      end
    end
    sel_is_zero = (sel_rw == ZeroAddr);
  end

  always_comb begin
    regwr_d    = 1'b0;
    rw_d       = rw_q;
    busw_d     = busw_q;
    wr_cnt_d   = wr_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (transfer) begin
      rw_d   = sel_rw;
      busw_d = sel_busw;
      if (sel_is_zero) begin
        if (drop_cnt_q != '1) begin
          drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
      end else begin
        regwr_d = 1'b1;
        if (wr_cnt_q != '1) begin
          wr_cnt_d = wr_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      regwr_q    <= 1'b0;
      rw_q       <= '0;
      busw_q     <= '0;
      wr_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      regwr_q    <= regwr_d;
      rw_q       <= rw_d;
      busw_q     <= busw_d;
      wr_cnt_q   <= wr_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign RegWr     = regwr_q;
  assign RW        = rw_q;
  assign BusW      = busw_q;
  assign WrCount   = wr_cnt_q;
  assign DropCount = drop_cnt_q;

`ifdef REGFILE_WB_FORWARD_EN
  // Bypass covers the posedge-to-negedge window before the register file commits.
  assign BusA_fwd = (regwr_q && (rw_q == RA) && (RA != ZeroAddr)) ? busw_q : BusA_in;
  assign BusB_fwd = (regwr_q && (rw_q == RB) && (RB != ZeroAddr)) ? busw_q : BusB_in;
`endif

endmodule
